// File: rtl/uart_rx.sv
// UART receiver: start, N data bits LSB first, optional even parity, M stops.
// Bits are sampled at mid-bit on a synchronized copy of the rx pin.
module uart_rx #(
  parameter int N         = 8,
  parameter int M         = 1,
  parameter int PARITY_EN = 0,
  parameter int BAUD_RATE = 9600,
  parameter int CLK_FREQ  = 50000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rx,
  output logic [N-1:0] data_out,
  output logic         rx_done,
  output logic         parity_err,
  output logic         frame_err
);

  localparam int C  = CLK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(C);
  localparam int MX = (N > M) ? N : M;
  localparam int BW = $clog2(MX + 1);

  localparam logic [CW-1:0] HALF   = CW'(C / 2 - 1);
  localparam logic [CW-1:0] FULL   = CW'(C - 1);
  localparam logic [BW-1:0] LAST_D = BW'(N - 1);
  localparam logic [BW-1:0] LAST_S = BW'(M - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state;
  logic          sync1;
  logic          rxs;
  logic          rxs_d;
  logic [CW-1:0] baud_cnt;
  logic [BW-1:0] bit_cnt;
  logic [N-1:0]  shreg;
  logic          perr_r;
  logic          ferr_r;
  logic          baud_hit;

  assign baud_hit = (baud_cnt == FULL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= rx;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      perr_r     <= 1'b0;
      ferr_r     <= 1'b0;
      data_out   <= '0;
      rx_done    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      unique case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          // only a true 1->0 edge starts a frame; a held-low line never does
          if (rxs_d && !rxs) begin
            state  <= START;
            perr_r <= 1'b0;
            ferr_r <= 1'b0;
          end
        end
        START: begin
          if (baud_cnt == HALF) begin
            baud_cnt <= '0;
            state    <= rxs ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_hit) begin
            baud_cnt <= '0;
            shreg    <= {rxs, shreg[N-1:1]};
            if (bit_cnt == LAST_D) begin
              bit_cnt <= '0;
              state   <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (baud_hit) begin
            baud_cnt <= '0;
            perr_r   <= rxs ^ (^shreg);
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_hit) begin
            baud_cnt <= '0;
            if (!rxs) ferr_r <= 1'b1;
            if (bit_cnt == LAST_S) begin
              bit_cnt    <= '0;
              state      <= IDLE;
              data_out   <= shreg;
              parity_err <= perr_r;
              frame_err  <= ferr_r | ~rxs;
              rx_done    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
